reorder_buffer: RTL and testbench

- Circular in-order retirement queue for the out-of-order core.
- Dispatch allocates one entry per cycle, carrying the new and old physical destination and the PC, and receives a ROB index tag in return.
- Execution units mark entries complete by tag.
- The oldest complete entry retires at most one per cycle and presents `pd_old` for return to the free list.
- Sits between rename/dispatch (writer) and the free list / architectural map commit (reader).

---
 rtl/reorder_buffer.sv | 114 +++++++++++
 tb/tb_reorder_buffer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue: dispatch allocates at the tail, execution
// units mark entries complete by tag, and the oldest complete entry retires.
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int PREG_W = 7,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid,
  input  logic [PREG_W-1:0] alloc_pd_new,
  input  logic [PREG_W-1:0] alloc_pd_old,
  input  logic [31:0]       alloc_pc,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  alloc_tag,
  input  logic              cmpl_valid,
  input  logic [IDX_W-1:0]  cmpl_tag,
  input  logic              flush,
  output logic              commit_valid,
  output logic [PREG_W-1:0] commit_pd_new,
  output logic [PREG_W-1:0] commit_pd_old,
  output logic [31:0]       commit_pc,
  output logic [IDX_W-1:0]  commit_tag,
  output logic [IDX_W:0]    count,
  output logic              empty,
  output logic              full
);

  // Handshakes: an allocation happens on a rising edge where alloc_valid and
  // alloc_ready are both high; a commit happens on every edge where
  // commit_valid is high (the reader never stalls); completions are
  // fire-and-forget and only take effect on a currently valid entry.

  logic [IDX_W:0]      r_head;
  logic [IDX_W:0]      r_tail;
  logic [DEPTH-1:0]    r_valid;
  logic [DEPTH-1:0]    r_complete;
  logic [PREG_W-1:0]   r_pd_new [DEPTH];
  logic [PREG_W-1:0]   r_pd_old [DEPTH];
  logic [31:0]         r_pc     [DEPTH];

  logic [IDX_W-1:0]    w_head_idx;
  logic [IDX_W-1:0]    w_tail_idx;
  logic                w_full;
  logic                w_empty;
  logic                w_alloc_fire;
  logic                w_commit_fire;
  logic                w_cmpl_fire;

  assign w_head_idx = r_head[IDX_W-1:0];
  assign w_tail_idx = r_tail[IDX_W-1:0];

  // Wrap bits distinguish full from empty when the low bits match.
  assign w_full  = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);
  assign w_empty = (r_head == r_tail);

  assign w_alloc_fire  = alloc_valid && alloc_ready;
  assign w_commit_fire = r_valid[w_head_idx] && r_complete[w_head_idx] && !flush;
  assign w_cmpl_fire   = cmpl_valid && r_valid[cmpl_tag] && !flush;

  assign alloc_ready   = !w_full && !flush;
  assign alloc_tag     = w_tail_idx;

  assign commit_valid  = w_commit_fire;
  assign commit_pd_new = r_pd_new[w_head_idx];
  assign commit_pd_old = r_pd_old[w_head_idx];
  assign commit_pc     = r_pc[w_head_idx];
  assign commit_tag    = w_head_idx;

  assign count = r_tail - r_head;
  assign empty = w_empty;
  assign full  = w_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_valid    <= '0;
      r_complete <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pd_new[i] <= '0;
        r_pd_old[i] <= '0;
        r_pc[i]     <= '0;
      end
    end else if (flush) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_valid    <= '0;
      r_complete <= '0;
    end else begin
      if (w_cmpl_fire) begin
        r_complete[cmpl_tag] <= 1'b1;
      end
      // The retiring head is already complete, so clearing it after the
      // completion update cannot lose a pending completion.
      if (w_commit_fire) begin
        r_valid[w_head_idx]    <= 1'b0;
        r_complete[w_head_idx] <= 1'b0;
        r_head                 <= r_head + 1'b1;
      end
      // The tail slot is never valid when allocation is allowed, so it cannot
      // collide with the completion or commit updates above.
      if (w_alloc_fire) begin
        r_valid[w_tail_idx]    <= 1'b1;
        r_complete[w_tail_idx] <= 1'b0;
        r_pd_new[w_tail_idx]   <= alloc_pd_new;
        r_pd_old[w_tail_idx]   <= alloc_pd_old;
        r_pc[w_tail_idx]       <= alloc_pc;
        r_tail                 <= r_tail + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: fill, out-of-order completion, full with
// commit, pointer wrap streaming, stray completion, same-cycle alloc/complete, flush.
module tb_reorder_buffer;

  logic        clk;
  logic        reset;
  logic        alloc_valid;
  logic [6:0]  alloc_pd_new;
  logic [6:0]  alloc_pd_old;
  logic [31:0] alloc_pc;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic        cmpl_valid;
  logic [3:0]  cmpl_tag;
  logic        flush;
  logic        commit_valid;
  logic [6:0]  commit_pd_new;
  logic [6:0]  commit_pd_old;
  logic [31:0] commit_pc;
  logic [3:0]  commit_tag;
  logic [4:0]  count;
  logic        empty;
  logic        full;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];

  reorder_buffer #(.DEPTH(16), .PREG_W(7), .IDX_W(4)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_pd_new(alloc_pd_new),
    .alloc_pd_old(alloc_pd_old), .alloc_pc(alloc_pc),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag), .flush(flush),
    .commit_valid(commit_valid), .commit_pd_new(commit_pd_new),
    .commit_pd_old(commit_pd_old), .commit_pc(commit_pc),
    .commit_tag(commit_tag), .count(count), .empty(empty), .full(full)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid  = 1'b0;
    alloc_pd_new = '0;
    alloc_pd_old = '0;
    alloc_pc     = '0;
    cmpl_valid   = 1'b0;
    cmpl_tag     = '0;
    flush        = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic set_alloc(input logic [6:0] pn, input logic [6:0] po, input logic [31:0] pc);
    alloc_valid  = 1'b1;
    alloc_pd_new = pn;
    alloc_pd_old = po;
    alloc_pc     = pc;
  endtask

  task automatic set_cmpl(input logic [3:0] tag);
    cmpl_valid = 1'b1;
    cmpl_tag   = tag;
  endtask

  // scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  int          n_commit;
  logic [3:0]  exp_tag;
  logic [3:0]  prev_tag;
  logic [31:0] popped;

  initial begin
    idle();
    reset = 1'b0;

    // Reset values
    do_reset();
    chk("rst_commit_valid", 32'(commit_valid), 32'd0);
    chk("rst_alloc_ready",  32'(alloc_ready),  32'd1);
    chk("rst_alloc_tag",    32'(alloc_tag),    32'd0);
    chk("rst_count",        32'(count),        32'd0);
    chk("rst_empty",        32'(empty),        32'd1);
    chk("rst_full",         32'(full),         32'd0);
    chk("rst_commit_pd_new", 32'(commit_pd_new), 32'd0);
    chk("rst_commit_pd_old", 32'(commit_pd_old), 32'd0);
    chk("rst_commit_pc",    commit_pc,         32'd0);
    chk("rst_commit_tag",   32'(commit_tag),   32'd0);

    // Fill 16 entries
    for (int i = 0; i < 16; i++) begin
      set_alloc(7'(32 + i), 7'(i), 32'h1000 + 32'(4 * i));
      #1;
      chk("fill_alloc_tag",   32'(alloc_tag),   32'(i));
      chk("fill_alloc_ready", 32'(alloc_ready), 32'd1);
      tick();
    end
    idle();
    #1;
    chk("fill_full",        32'(full),         32'd1);
    chk("fill_alloc_ready", 32'(alloc_ready),  32'd0);
    chk("fill_count",       32'(count),        32'd16);
    chk("fill_empty",       32'(empty),        32'd0);
    chk("fill_no_commit",   32'(commit_valid), 32'd0);
    set_alloc(7'd99, 7'd99, 32'hdead0000);
    #1;
    chk("ovf_alloc_ready",  32'(alloc_ready),  32'd0);
    tick();
    chk("ovf_count",        32'(count),        32'd16);
    chk("ovf_alloc_tag",    32'(alloc_tag),    32'd0);

    // Full plus commit
    idle();
    set_cmpl(4'd0);
    tick();
    idle();
    #1;
    chk("fc_commit_valid",  32'(commit_valid),  32'd1);
    chk("fc_commit_tag",    32'(commit_tag),    32'd0);
    chk("fc_commit_pd_new", 32'(commit_pd_new), 32'd32);
    chk("fc_commit_pd_old", 32'(commit_pd_old), 32'd0);
    chk("fc_commit_pc",     commit_pc,          32'h1000);
    set_alloc(7'd100, 7'd50, 32'h2000);
    #1;
    chk("fc_alloc_blocked", 32'(alloc_ready),  32'd0);
    chk("fc_commit_same",   32'(commit_valid), 32'd1);
    tick();
    chk("fc_count_after",   32'(count),        32'd15);
    chk("fc_ready_after",   32'(alloc_ready),  32'd1);
    chk("fc_tag_after",     32'(alloc_tag),    32'd0);
    chk("fc_full_after",    32'(full),         32'd0);
    tick();
    idle();
    #1;
    chk("fc_wrap_count",    32'(count),        32'd16);
    chk("fc_wrap_full",     32'(full),         32'd1);
    chk("fc_head_tag",      32'(commit_tag),   32'd1);
    chk("fc_head_pending",  32'(commit_valid), 32'd0);

    // Out-of-order completion
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_alloc(7'(40 + i), 7'(i), 32'h3000 + 32'(4 * i));
      tick();
    end
    idle();
    set_cmpl(4'd3);
    #1;
    chk("ooo_wait3", 32'(commit_valid), 32'd0);
    tick();
    set_cmpl(4'd1);
    #1;
    chk("ooo_wait1", 32'(commit_valid), 32'd0);
    tick();
    set_cmpl(4'd2);
    #1;
    chk("ooo_wait2", 32'(commit_valid), 32'd0);
    tick();
    set_cmpl(4'd0);
    #1;
    chk("ooo_wait0", 32'(commit_valid), 32'd0);
    tick();
    idle();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("ooo_commit_valid",  32'(commit_valid),  32'd1);
      chk("ooo_commit_tag",    32'(commit_tag),    32'(k));
      chk("ooo_commit_pd_old", 32'(commit_pd_old), 32'(k));
      chk("ooo_commit_pc",     commit_pc,          32'h3000 + 32'(4 * k));
      tick();
    end
    chk("ooo_empty",     32'(empty),        32'd1);
    chk("ooo_no_commit", 32'(commit_valid), 32'd0);

    // Wrap-around stream: head=tail=4, 40 entries cross the wrap point twice
    n_commit = 0;
    exp_tag  = 4'd4;
    prev_tag = 4'd0;
    for (int c = 0; c < 44; c++) begin
      idle();
      if (c < 40) set_alloc(7'(c), 7'(c), 32'h4000 + 32'(4 * c));
      if (c >= 1 && c <= 40) set_cmpl(prev_tag);
      #1;
      chk("wrap_count", 32'(count), 32'(exp_q.size()));
      chk("wrap_count_max", 32'(count <= 5'd16), 32'd1);
      if (c < 40) chk("wrap_alloc_tag", 32'(alloc_tag), 32'(exp_tag));
      if (commit_valid) begin
        if (exp_q.size() == 0) begin
          chk("wrap_spurious_commit", 32'd1, 32'd0);
        end else begin
          popped = exp_q.pop_front();
          chk("wrap_commit_pc", commit_pc, popped);
          n_commit++;
        end
      end
      if (alloc_valid && alloc_ready) begin
        exp_q.push_back(alloc_pc);
        prev_tag = exp_tag;
        exp_tag  = exp_tag + 4'd1;
      end
      tick();
    end
    idle();
    #1;
    chk("wrap_commits", 32'(n_commit), 32'd40);
    chk("wrap_empty",   32'(empty),    32'd1);

    // Completion to a free slot
    do_reset();
    set_cmpl(4'd7);
    tick();
    idle();
    #1;
    chk("stray_count",  32'(count),        32'd0);
    chk("stray_empty",  32'(empty),        32'd1);
    chk("stray_commit", 32'(commit_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      set_alloc(7'(60 + i), 7'(i), 32'h5000 + 32'(4 * i));
      tick();
    end
    idle();
    for (int k = 0; k < 7; k++) begin
      set_cmpl(4'(k));
      tick();
    end
    idle();
    for (int k = 0; k < 4; k++) tick();
    chk("slot7_not_complete", 32'(commit_valid), 32'd0);
    chk("slot7_count",        32'(count),        32'd1);
    chk("slot7_head",         32'(commit_tag),   32'd7);
    chk("slot7_pc",           commit_pc,         32'h501c);
    set_cmpl(4'd7);
    tick();
    idle();
    #1;
    chk("slot7_commit",        32'(commit_valid),  32'd1);
    chk("slot7_commit_pd_old", 32'(commit_pd_old), 32'd7);
    chk("slot7_commit_pd_new", 32'(commit_pd_new), 32'd67);
    tick();
    chk("slot7_empty", 32'(empty), 32'd1);

    // Same-cycle allocate and completion while empty (head=tail=8)
    set_alloc(7'd70, 7'd20, 32'h6000);
    set_cmpl(4'd8);
    #1;
    chk("same_alloc_tag", 32'(alloc_tag), 32'd8);
    tick();
    idle();
    #1;
    chk("same_count",     32'(count),        32'd1);
    chk("same_no_commit", 32'(commit_valid), 32'd0);
    tick();
    chk("same_still_no_commit", 32'(commit_valid), 32'd0);
    set_cmpl(4'd8);
    tick();
    idle();
    #1;
    chk("same_commit",     32'(commit_valid), 32'd1);
    chk("same_commit_pc",  commit_pc,         32'h6000);
    tick();
    chk("same_empty", 32'(empty), 32'd1);

    // Flush with 5 entries (tags 9..13), 9 and 10 complete at the head
    for (int i = 0; i < 5; i++) begin
      set_alloc(7'(80 + i), 7'(i), 32'h7000 + 32'(4 * i));
      tick();
    end
    idle();
    set_cmpl(4'd10);
    tick();
    set_cmpl(4'd9);
    tick();
    idle();
    #1;
    chk("pre_flush_commit", 32'(commit_valid), 32'd1);
    chk("pre_flush_count",  32'(count),        32'd5);
    chk("pre_flush_head",   32'(commit_tag),   32'd9);
    flush = 1'b1;
    set_alloc(7'd90, 7'd90, 32'h8000);
    set_cmpl(4'd11);
    #1;
    chk("flush_commit_valid", 32'(commit_valid), 32'd0);
    chk("flush_alloc_ready",  32'(alloc_ready),  32'd0);
    tick();
    idle();
    #1;
    chk("post_flush_empty",     32'(empty),        32'd1);
    chk("post_flush_count",     32'(count),        32'd0);
    chk("post_flush_alloc_tag", 32'(alloc_tag),    32'd0);
    chk("post_flush_full",      32'(full),         32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("post_flush_no_commit", 32'(commit_valid), 32'd0);
      tick();
    end
    set_alloc(7'd91, 7'd91, 32'h9000);
    #1;
    chk("post_flush_new_tag", 32'(alloc_tag), 32'd0);
    tick();
    idle();
    #1;
    chk("post_flush_new_count", 32'(count), 32'd1);

    // Reset mid-operation discards the entry
    set_cmpl(4'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    #1;
    chk("midrst_count",  32'(count),        32'd0);
    chk("midrst_empty",  32'(empty),        32'd1);
    chk("midrst_commit", 32'(commit_valid), 32'd0);
    chk("midrst_pc",     commit_pc,         32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
